srl_2_prll_deser: RTL and testbench
===================================

// Module: srl_2_prll_deser
// PURPOSE
//   Parametrised serial-to-parallel deserializer; successor to the fixed 4-bit converter.
//   Accepts one qualified serial bit per clk, with MSB- or LSB-first ordering and frame-start resync.
//   Presents completed words through a one-entry output register with a valid/ready handshake.
//   Sits between a bit-serial front end (UART/SPI-style sampler) and word-level logic.
// PARAMETERS
//   WIDTH      8   word width in bits, >= 2
//   MSB_FIRST  1   1: first bit received lands in prll_o[WIDTH-1]; 0: first bit lands in prll_o[0]
//   PAR_ODD    0   parity sense (used only with SRL2PRLL_PARITY_EN): 0 even, 1 odd
// PORTS
//   clk           in   1      clock, all logic on rising edge
//   reset         in   1      synchronous, active-high reset
//   srl_in        in   1      serial data bit
//   srl_valid_i   in   1      srl_in is sampled this cycle
//   srl_start_i   in   1      with srl_valid_i: this bit is bit 0 of a new frame
//   prll_o        out  WIDTH  deserialized word
//   valid_o       out  1      prll_o holds an unconsumed word
//   ready_i       in   1      consumer takes the word when valid_o && ready_i
//   overflow_o    out  1      sticky: a completed word was dropped
//   parity_err_o  out  1      parity error flag for the word in prll_o
// BEHAVIOUR
//   Reset: prll_o=0, valid_o=0, overflow_o=0, parity_err_o=0, bit counter=0, shift reg=0, FSM=IDLE.
//   FSM: IDLE (no partial word) -> SHIFT on the first valid bit.
//     SHIFT -> IDLE on bit WIDTH-1, or -> PARITY on that bit when SRL2PRLL_PARITY_EN.
//     PARITY -> IDLE on the next valid bit.
//   Bit counter is $clog2(WIDTH) bits and advances only when srl_valid_i=1.
//     It wraps to 0 on word completion; back-to-back words need no idle cycle.
//   srl_start_i && srl_valid_i: discard any partial word and count this bit as bit 0.
//     srl_start_i without srl_valid_i is ignored. A start in IDLE behaves as a normal first bit.
//   Word completes on the edge that samples the last frame bit.
//     valid_o rises the following cycle (latency 1 clk from the last bit).
//   Handshake: the word is held stable while valid_o && !ready_i; valid_o falls the cycle after the accept.
//   Load rule at completion:
//     - if !valid_o, or ready_i is high the same cycle, load the new word; valid_o stays or goes 1.
//     - otherwise drop the new word, keep the old one, set overflow_o.
//   overflow_o clears only on reset. The serial side is never back-pressured.
//   Reset mid-frame discards the partial word and any held word.
// CONFIGURATION
//   SRL2PRLL_PARITY_EN defined:
//     - frame is WIDTH+1 bits; the last bit is parity over the WIDTH data bits (sense per PAR_ODD).
//     - parity_err_o is loaded with prll_o and is valid while valid_o=1.
//     - dropped words do not update parity_err_o.
//   SRL2PRLL_PARITY_EN undefined: frame is WIDTH bits, no PARITY state, parity_err_o tied 0.
// STRUCTURE
//   Shared package srl_2_prll_pkg holds:
//     - FSM state encodings ST_IDLE, ST_SHIFT, ST_PARITY;
//     - the counter-width function (clog2).
//   One sub-module, srl_2_prll_shreg: WIDTH-bit shift register with direction selected by MSB_FIRST,
//     plus clear-on-start.
//   Top level contains the FSM, bit counter, output register/handshake, overflow and parity logic.
// TESTING
//   1. WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,0,1 on consecutive cycles, ready_i=1
//      -> valid_o one cycle after the 8th bit, prll_o=8'hB1.
//   2. Same bits with MSB_FIRST=0 -> prll_o=8'h8D.
//   3. Two back-to-back words 8'hB1 then 8'h3C with ready_i=0
//      -> prll_o stays 8'hB1, valid_o=1, overflow_o=1 after the second word;
//      then ready_i=1 -> valid_o=0 next cycle.
//   4. Three bits, then srl_start_i with bits of 8'h5A
//      -> prll_o=8'h5A, partial discarded, overflow_o=0.
//   5. srl_valid_i toggling 1/0 every cycle while sending 8'hC3 -> prll_o=8'hC3 after 16 cycles.
//      reset asserted mid-word -> all outputs 0 next cycle.
//   6. SRL2PRLL_PARITY_EN, PAR_ODD=0: 8'hB1 with parity bit 0 -> parity_err_o=0;
//      parity bit 1 -> parity_err_o=1.

Source files
------------

// File: rtl/srl_2_prll_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state encodings
// and the bit-counter width helper.
package srl_2_prll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Ceiling log2, used to size the in-frame bit counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/srl_2_prll_deser_if.sv
// Serial-in / word-out bus of the deserializer. The master drives the serial stream
// and consumer ready; the slave (the deserializer) returns the word and status flags.
interface srl_2_prll_deser_if #(
    parameter int WIDTH = 8
);
    logic             srl_in;
    logic             srl_valid_i;
    logic             srl_start_i;
    logic             ready_i;
    logic [WIDTH-1:0] prll_o;
    logic             valid_o;
    logic             overflow_o;
    logic             parity_err_o;

    modport master (
        output srl_in, srl_valid_i, srl_start_i, ready_i,
        input  prll_o, valid_o, overflow_o, parity_err_o
    );

    modport slave (
        input  srl_in, srl_valid_i, srl_start_i, ready_i,
        output prll_o, valid_o, overflow_o, parity_err_o
    );
endinterface

// File: rtl/srl_2_prll_shreg.sv
// WIDTH-bit shift register; MSB_FIRST selects whether bits enter at the LSB and move up
// (first bit ends in [WIDTH-1]) or enter at the MSB and move down (first bit ends in [0]).
module srl_2_prll_shreg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] base;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        base = clear ? '0 : q;
        word = q;
        if (shift_en) begin
            if (MSB_FIRST != 0) word = {base[WIDTH-2:0], bit_in};
            else                word = {bit_in, base[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking '<='; the register is small, so it is reset like any flop.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= word;
    end

endmodule

// File: rtl/srl_2_prll_deser.sv
// Serial-to-parallel deserializer with frame-start resync and a one-entry valid/ready output.
// Define SRL2PRLL_PARITY_EN to append a parity bit to each frame and report parity_err_o.
module srl_2_prll_deser
    import srl_2_prll_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PAR_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    srl_2_prll_deser_if.slave     bus
);
    localparam int CW = clog2(WIDTH);
`ifdef SRL2PRLL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    if (WIDTH < 2 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_param
        $error("srl_2_prll_deser: WIDTH must be >= 2 and PAR_ODD 0 or 1");
    end

    state_e           state, state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             bit_fire, frame_start, last_data_bit;
    logic             shift_en, shift_clr, word_done, load_word;
    logic [WIDTH-1:0] word;

    assign bit_fire      = bus.srl_valid_i;
    assign frame_start   = bus.srl_valid_i && bus.srl_start_i;
    assign last_data_bit = (bit_cnt == CW'(WIDTH - 1));
    assign load_word     = word_done && (!bus.valid_o || bus.ready_i);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (bit_fire) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (frame_start)                  state_nxt = ST_SHIFT;
                       else if (bit_fire && last_data_bit) state_nxt = PARITY_EN ? ST_PARITY : ST_IDLE;
            ST_PARITY: if (frame_start)   state_nxt = ST_SHIFT;
                       else if (bit_fire) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The parity bit is not shifted in, so the register already holds the data when it arrives.
    always_comb begin
        shift_en  = bit_fire && (state != ST_PARITY || frame_start);
        shift_clr = frame_start || (bit_fire && state == ST_IDLE);
        word_done = bit_fire && !frame_start &&
                    ((state == ST_SHIFT && last_data_bit && !PARITY_EN) || state == ST_PARITY);
    end

    always_ff @(posedge clk) begin
        if (reset)                   bit_cnt <= '0;
        else if (bit_fire) begin
            if (shift_clr)           bit_cnt <= CW'(1);
            else if (state == ST_SHIFT)
                bit_cnt <= last_data_bit ? '0 : bit_cnt + CW'(1);
            else                     bit_cnt <= '0;
        end
    end

    srl_2_prll_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clear    (shift_clr),
        .bit_in   (bus.srl_in),
        .word     (word)
    );

    // A completed word is dropped only when the held one is neither free nor leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.prll_o     <= '0;
            bus.valid_o    <= 1'b0;
            bus.overflow_o <= 1'b0;
        end else if (word_done) begin
            if (load_word) begin
                bus.prll_o  <= word;
                bus.valid_o <= 1'b1;
            end else begin
                bus.overflow_o <= 1'b1;
            end
        end else if (bus.valid_o && bus.ready_i) begin
            bus.valid_o <= 1'b0;
        end
    end

`ifdef SRL2PRLL_PARITY_EN
    logic par_bad;
    assign par_bad = ((^word) ^ bus.srl_in) != (PAR_ODD != 0);

    always_ff @(posedge clk) begin
        if (reset)          bus.parity_err_o <= 1'b0;
        else if (load_word) bus.parity_err_o <= par_bad;
    end
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_srl_2_prll_deser.sv
// Directed bench: an MSB-first and an LSB-first deserializer receive the same serial stream.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_srl_2_prll_deser;
    localparam int W          = 8;
    localparam int PAR_ODD_TB = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic srl_in = 1'b0, srl_valid = 1'b0, srl_start = 1'b0, ready = 1'b1;
    logic valid_at_last;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    srl_2_prll_deser_if #(.WIDTH(W)) bus_msb ();
    srl_2_prll_deser_if #(.WIDTH(W)) bus_lsb ();

    assign bus_msb.srl_in      = srl_in;
    assign bus_msb.srl_valid_i = srl_valid;
    assign bus_msb.srl_start_i = srl_start;
    assign bus_msb.ready_i     = ready;
    assign bus_lsb.srl_in      = srl_in;
    assign bus_lsb.srl_valid_i = srl_valid;
    assign bus_lsb.srl_start_i = srl_start;
    assign bus_lsb.ready_i     = ready;

    srl_2_prll_deser #(.WIDTH(W), .MSB_FIRST(1), .PAR_ODD(PAR_ODD_TB))
        dut_msb (.clk(clk), .reset(reset), .bus(bus_msb));
    srl_2_prll_deser #(.WIDTH(W), .MSB_FIRST(0), .PAR_ODD(PAR_ODD_TB))
        dut_lsb (.clk(clk), .reset(reset), .bus(bus_lsb));

    task automatic idle();
        @(negedge clk);
        srl_valid = 1'b0; srl_start = 1'b0; srl_in = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input logic st);
        @(negedge clk);
        srl_in = b; srl_valid = 1'b1; srl_start = st;
    endtask

    // Data bits go out w[7] first; the parity bit follows only in parity builds.
    task automatic send_frame(input logic [7:0] w, input logic pbit, input logic st);
        for (int i = 7; i >= 0; i--) drive_bit(w[i], st && (i == 7));
`ifdef SRL2PRLL_PARITY_EN
        drive_bit(pbit, 1'b0);
`endif
        valid_at_last = bus_msb.valid_o;
    endtask

    task automatic send_word(input logic [7:0] w, input logic st);
        send_frame(w, (^w) ^ (PAR_ODD_TB != 0), st);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; srl_valid = 1'b0; srl_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ready = 1'b0;
        drive_bit(1'b1, 1'b0);
        do_reset();
        vec_cnt++; if (bus_msb.prll_o !== 8'h00) begin err_cnt++; $display("FAIL reset_prll: got %h expected 00", bus_msb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b expected 0", bus_msb.overflow_o); end
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b0) begin err_cnt++; $display("FAIL reset_parity: got %b expected 0", bus_msb.parity_err_o); end
        vec_cnt++; if (bus_lsb.valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid_lsb: got %b expected 0", bus_lsb.valid_o); end
    endtask

    task automatic test_bit_order();
        do_reset();
        ready = 1'b1;
        send_word(8'hB1, 1'b0);
        vec_cnt++; if (valid_at_last !== 1'b0) begin err_cnt++; $display("FAIL order_early_valid: got %b expected 0", valid_at_last); end
        idle();
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL order_valid: got %b expected 1", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.prll_o !== 8'hB1) begin err_cnt++; $display("FAIL order_msb_word: got %h expected b1", bus_msb.prll_o); end
        vec_cnt++; if (bus_lsb.prll_o !== 8'h8D) begin err_cnt++; $display("FAIL order_lsb_word: got %h expected 8d", bus_lsb.prll_o); end
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b0) begin err_cnt++; $display("FAIL order_parity: got %b expected 0", bus_msb.parity_err_o); end
        idle();
        vec_cnt++; if (bus_msb.valid_o !== 1'b0) begin err_cnt++; $display("FAIL order_accept: got %b expected 0", bus_msb.valid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b0;
        send_word(8'hB1, 1'b0);
        send_word(8'h3C, 1'b0);
        vec_cnt++; if (valid_at_last !== 1'b1) begin err_cnt++; $display("FAIL b2b_held_valid: got %b expected 1", valid_at_last); end
        idle();
        vec_cnt++; if (bus_msb.prll_o !== 8'hB1) begin err_cnt++; $display("FAIL b2b_kept_word: got %h expected b1", bus_msb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid: got %b expected 1", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_overflow: got %b expected 1", bus_msb.overflow_o); end
        vec_cnt++; if (bus_lsb.overflow_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_overflow_lsb: got %b expected 1", bus_lsb.overflow_o); end
        ready = 1'b1;
        idle();
        vec_cnt++; if (bus_msb.valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_accept: got %b expected 0", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_overflow_sticky: got %b expected 1", bus_msb.overflow_o); end
    endtask

    task automatic test_resync();
        do_reset();
        ready = 1'b1;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        send_word(8'h5A, 1'b1);
        idle();
        vec_cnt++; if (bus_msb.prll_o !== 8'h5A) begin err_cnt++; $display("FAIL resync_word: got %h expected 5a", bus_msb.prll_o); end
        vec_cnt++; if (bus_lsb.prll_o !== 8'h5A) begin err_cnt++; $display("FAIL resync_word_lsb: got %h expected 5a", bus_lsb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL resync_valid: got %b expected 1", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b0) begin err_cnt++; $display("FAIL resync_overflow: got %b expected 0", bus_msb.overflow_o); end
    endtask

    // Every other cycle is unqualified, with a stray start and an inverted bit that must be ignored.
    task automatic test_gapped_valid();
        logic [7:0] w;
        logic       pb;
        w  = 8'hC3;
        pb = (^w) ^ (PAR_ODD_TB != 0);
        do_reset();
        ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(w[i], 1'b0);
            @(negedge clk);
            srl_valid = 1'b0; srl_start = 1'b1; srl_in = ~w[i];
        end
`ifdef SRL2PRLL_PARITY_EN
        drive_bit(pb, 1'b0);
        @(negedge clk);
        srl_valid = 1'b0; srl_start = 1'b1; srl_in = ~pb;
`endif
        vec_cnt++; if (bus_msb.prll_o !== 8'hC3) begin err_cnt++; $display("FAIL gapped_word: got %h expected c3", bus_msb.prll_o); end
        vec_cnt++; if (bus_lsb.prll_o !== 8'hC3) begin err_cnt++; $display("FAIL gapped_word_lsb: got %h expected c3", bus_lsb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL gapped_valid: got %b expected 1", bus_msb.valid_o); end
        srl_start = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        ready = 1'b0;
        send_word(8'hA5, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        vec_cnt++; if (bus_msb.prll_o !== 8'hA5) begin err_cnt++; $display("FAIL mid_held_word: got %h expected a5", bus_msb.prll_o); end
        @(negedge clk);
        reset = 1'b1; srl_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus_msb.prll_o !== 8'h00) begin err_cnt++; $display("FAIL mid_reset_prll: got %h expected 00", bus_msb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_valid: got %b expected 0", bus_msb.valid_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_overflow: got %b expected 0", bus_msb.overflow_o); end
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_parity: got %b expected 0", bus_msb.parity_err_o); end
        reset = 1'b0;
        ready = 1'b1;
        send_word(8'h0F, 1'b0);
        idle();
        vec_cnt++; if (bus_msb.prll_o !== 8'h0F) begin err_cnt++; $display("FAIL mid_fresh_word: got %h expected 0f", bus_msb.prll_o); end
        vec_cnt++; if (bus_lsb.prll_o !== 8'hF0) begin err_cnt++; $display("FAIL mid_fresh_word_lsb: got %h expected f0", bus_lsb.prll_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL mid_fresh_valid: got %b expected 1", bus_msb.valid_o); end
    endtask

`ifdef SRL2PRLL_PARITY_EN
    task automatic test_parity();
        do_reset();
        ready = 1'b1;
        send_frame(8'hB1, 1'b0, 1'b0);
        idle();
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b0) begin err_cnt++; $display("FAIL parity_good: got %b expected 0", bus_msb.parity_err_o); end
        vec_cnt++; if (bus_msb.prll_o !== 8'hB1) begin err_cnt++; $display("FAIL parity_good_word: got %h expected b1", bus_msb.prll_o); end
        send_frame(8'hB1, 1'b1, 1'b0);
        idle();
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b1) begin err_cnt++; $display("FAIL parity_bad: got %b expected 1", bus_msb.parity_err_o); end
        vec_cnt++; if (bus_lsb.parity_err_o !== 1'b1) begin err_cnt++; $display("FAIL parity_bad_lsb: got %b expected 1", bus_lsb.parity_err_o); end
        vec_cnt++; if (bus_msb.valid_o !== 1'b1) begin err_cnt++; $display("FAIL parity_bad_valid: got %b expected 1", bus_msb.valid_o); end
        ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle();
        vec_cnt++; if (bus_msb.parity_err_o !== 1'b1) begin err_cnt++; $display("FAIL parity_drop_keep: got %b expected 1", bus_msb.parity_err_o); end
        vec_cnt++; if (bus_msb.overflow_o !== 1'b1) begin err_cnt++; $display("FAIL parity_drop_overflow: got %b expected 1", bus_msb.overflow_o); end
        ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_resync();
        test_gapped_valid();
        test_reset_mid_word();
`ifdef SRL2PRLL_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
